// File: rtl/bg_scene_ctrl_if.sv
// VGA timing stream as seen by the background stages.
// The scene sequencer only monitors vertical blanking.
interface vga_if;
    logic vblnk;

    modport master (output vblnk);
    modport slave  (input  vblnk);
    modport in     (input  vblnk);
endinterface

// File: rtl/bg_scene_ctrl.sv
// Frame-synchronous scene sequencer for the background stage: collects game
// events at any time and applies them only on the rising edge of vblnk.
module bg_scene_ctrl #(
    parameter int FADE_STEP    = 2,
    parameter int FLASH_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.in           vga_in,
    input  logic        start_req,
    input  logic        hit_req,
    input  logic        over_req,
    output logic [11:0] bg_rgb,
    output logic        border_en,
    output logic [2:0]  scene,
    output logic        frame_tick
);

    typedef enum logic [2:0] {
        TITLE    = 3'd0,
        FADE     = 3'd1,
        PLAY     = 3'd2,
        FLASH    = 3'd3,
        GAMEOVER = 3'd4
    } scene_e;

    localparam logic [7:0] STEP_LAST = 8'(FADE_STEP - 1);
    localparam logic [7:0] FLASH_LEN = 8'(FLASH_FRAMES);

    scene_e      state_q, state_d;
    logic        vblnk_q;
    logic [3:0]  lvl_q, lvl_d;
    logic [7:0]  step_q, step_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        p_start_q, p_start_d;
    logic        p_hit_q, p_hit_d;
    logic        p_over_q, p_over_d;
    logic [11:0] rgb_q, rgb_d;
    logic        border_q, border_d;
    logic        tick_q;

    logic        fb;
    logic        start_ok, hit_ok, over_ok;
    logic        want_start, want_hit, want_over;

    function automatic logic [11:0] scene_rgb(scene_e s, logic [3:0] lvl, logic [7:0] cnt);
        case (s)
            TITLE:    return 12'h004;
            FADE:     return {lvl, lvl, lvl};
            PLAY:     return 12'h111;
            FLASH:    return cnt[0] ? 12'h111 : 12'hF00;
            GAMEOVER: return 12'h400;
            default:  return 12'h004;
        endcase
    endfunction

    assign fb = vga_in.vblnk & ~vblnk_q;

    // Requests are filtered by the scene they arrive in, not the one they land in.
    assign start_ok = start_req & ((state_q == TITLE) || (state_q == GAMEOVER));
    assign hit_ok   = hit_req   & ((state_q == PLAY)  || (state_q == FLASH));
    assign over_ok  = over_req  & ((state_q == FADE)  || (state_q == PLAY) || (state_q == FLASH));

    assign want_start = p_start_q | start_ok;
    assign want_hit   = p_hit_q   | hit_ok;
    assign want_over  = p_over_q  | over_ok;

    always_comb begin
        p_start_d = fb ? 1'b0 : want_start;
        p_hit_d   = fb ? 1'b0 : want_hit;
        p_over_d  = fb ? 1'b0 : want_over;
    end

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        if (fb) begin
            if (want_over) begin
                state_d = GAMEOVER;
            end else if (want_hit) begin
                state_d = FLASH;
                cnt_d   = 8'd0;
            end else if (want_start) begin
                state_d = FADE;
                lvl_d   = 4'hF;
                step_d  = 8'd0;
            end else begin
                case (state_q)
                    FADE: begin
                        if (step_q == STEP_LAST) begin
                            step_d = 8'd0;
                            // Level 1 is never shown; PLAY takes over instead.
                            if (lvl_q == 4'd2) state_d = PLAY;
                            else               lvl_d   = lvl_q - 4'd1;
                        end else begin
                            step_d = step_q + 8'd1;
                        end
                    end
                    FLASH: begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_d == FLASH_LEN) state_d = PLAY;
                    end
                    default: ;
                endcase
            end
        end
        rgb_d    = scene_rgb(state_d, lvl_d, cnt_d);
        border_d = (state_d != GAMEOVER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= TITLE;
            vblnk_q   <= 1'b0;
            lvl_q     <= 4'd0;
            step_q    <= 8'd0;
            cnt_q     <= 8'd0;
            p_start_q <= 1'b0;
            p_hit_q   <= 1'b0;
            p_over_q  <= 1'b0;
            rgb_q     <= 12'h004;
            border_q  <= 1'b1;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vblnk_q   <= vga_in.vblnk;
            lvl_q     <= lvl_d;
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            p_start_q <= p_start_d;
            p_hit_q   <= p_hit_d;
            p_over_q  <= p_over_d;
            rgb_q     <= rgb_d;
            border_q  <= border_d;
            tick_q    <= fb;
        end
    end

    assign scene      = state_q;
    assign bg_rgb     = rgb_q;
    assign border_en  = border_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_bg_scene_ctrl.sv
// Scoreboard bench for bg_scene_ctrl: expected per-frame outputs are queued as
// frames are driven; a monitor pops one entry on every frame_tick.
`timescale 1ns/1ps
module tb_bg_scene_ctrl;

    typedef struct packed {
        logic [2:0]  sc;
        logic [11:0] rgb;
        logic        bd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_req = 1'b0;
    logic        hit_req = 1'b0;
    logic        over_req = 1'b0;
    logic [11:0] bg_rgb;
    logic        border_en;
    logic [2:0]  scene;
    logic        frame_tick;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    exp_t last;
    exp_t e;
    logic tick_prev = 1'b0;
    logic [3:0] lv;

    vga_if vga();

    bg_scene_ctrl #(.FADE_STEP(2), .FLASH_FRAMES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .vga_in     (vga),
        .start_req  (start_req),
        .hit_req    (hit_req),
        .over_req   (over_req),
        .bg_rgb     (bg_rgb),
        .border_en  (border_en),
        .scene      (scene),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: one scoreboard entry per frame_tick, outputs frozen otherwise.
    always @(negedge clk) begin
        if (rst) begin
            last      = exp_t'{3'd0, 12'h004, 1'b1};
            tick_prev = 1'b0;
        end else if (frame_tick) begin
            check("tick_width", {31'd0, tick_prev}, 32'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_tick: scene=%0d bg=%03h, expected no tick", scene, bg_rgb);
            end else begin
                e = exp_q.pop_front();
                check("scene",     {29'd0, scene},     {29'd0, e.sc});
                check("bg_rgb",    {20'd0, bg_rgb},    {20'd0, e.rgb});
                check("border_en", {31'd0, border_en}, {31'd0, e.bd});
                last = e;
            end
            tick_prev = 1'b1;
        end else begin
            check("hold", {16'd0, scene, bg_rgb, border_en}, {16'd0, last});
            tick_prev = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fb(input logic [2:0] sc, input logic [11:0] rgb, input logic bd);
        exp_q.push_back(exp_t'{sc, rgb, bd});
    endtask

    // One frame: vblnk low with an optional mid-frame pulse {over,hit,start}, then rise.
    task automatic frame(input logic [2:0] req);
        vga.vblnk = 1'b0;
        step();
        {over_req, hit_req, start_req} = req;
        step();
        {over_req, hit_req, start_req} = 3'b000;
        step();
        vga.vblnk = 1'b1;
        repeat (3) step();
    endtask

    task automatic fade_to_play();
        for (int k = 1; k < 28; k++) begin
            lv = 4'(15 - k / 2);
            expect_fb(3'd1, {lv, lv, lv}, 1'b1);
            frame(3'b000);
        end
        expect_fb(3'd2, 12'h111, 1'b1);
        frame(3'b000);
    endtask

    initial begin
        vga.vblnk = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_scene",  {29'd0, scene},      32'd0);
        check("rst_bg",     {20'd0, bg_rgb},     32'h004);
        check("rst_border", {31'd0, border_en},  32'd1);
        check("rst_tick",   {31'd0, frame_tick}, 32'd0);

        // First boundary in TITLE: tick one cycle after the rise, one cycle wide.
        expect_fb(3'd0, 12'h004, 1'b1);
        vga.vblnk = 1'b1;
        step();
        check("tick_rise", {31'd0, frame_tick}, 32'd1);
        step();
        check("tick_fall", {31'd0, frame_tick}, 32'd0);
        step();

        // Mid-frame start waits for the boundary.
        vga.vblnk = 1'b0;
        step();
        start_req = 1'b1;
        step();
        start_req = 1'b0;
        check("title_hold", {29'd0, scene}, 32'd0);
        step();
        expect_fb(3'd1, 12'hFFF, 1'b1);
        vga.vblnk = 1'b1;
        repeat (3) step();
        fade_to_play();

        // Full flash then back to PLAY.
        expect_fb(3'd3, 12'hF00, 1'b1);
        frame(3'b010);
        for (int j = 1; j < 8; j++) begin
            expect_fb(3'd3, j[0] ? 12'h111 : 12'hF00, 1'b1);
            frame(3'b000);
        end
        expect_fb(3'd2, 12'h111, 1'b1);
        frame(3'b000);

        // Flash restarted by a hit while the fifth flash frame is shown.
        expect_fb(3'd3, 12'hF00, 1'b1);
        frame(3'b010);
        for (int j = 1; j < 5; j++) begin
            expect_fb(3'd3, j[0] ? 12'h111 : 12'hF00, 1'b1);
            frame(3'b000);
        end
        expect_fb(3'd3, 12'hF00, 1'b1);
        frame(3'b010);
        for (int j = 1; j < 8; j++) begin
            expect_fb(3'd3, j[0] ? 12'h111 : 12'hF00, 1'b1);
            frame(3'b000);
        end
        expect_fb(3'd2, 12'h111, 1'b1);
        frame(3'b000);

        // hit and over in the same frame: over wins.
        expect_fb(3'd4, 12'h400, 1'b0);
        frame(3'b110);

        // over in GAMEOVER is dropped.
        for (int j = 0; j < 3; j++) begin
            expect_fb(3'd4, 12'h400, 1'b0);
            frame(3'b100);
        end

        // start coincident with the boundary cycle.
        vga.vblnk = 1'b0;
        repeat (3) step();
        expect_fb(3'd1, 12'hFFF, 1'b1);
        vga.vblnk = 1'b1;
        start_req = 1'b1;
        step();
        start_req = 1'b0;
        check("coinc_scene", {29'd0, scene}, 32'd1);
        repeat (2) step();
        fade_to_play();

        // Reset mid-flash with hit and over pending.
        expect_fb(3'd3, 12'hF00, 1'b1);
        frame(3'b010);
        expect_fb(3'd3, 12'h111, 1'b1);
        frame(3'b000);
        vga.vblnk = 1'b0;
        step();
        hit_req = 1'b1;
        step();
        hit_req = 1'b0;
        over_req = 1'b1;
        step();
        over_req = 1'b0;
        rst = 1'b1;
        step();
        check("midrst_scene",  {29'd0, scene},     32'd0);
        check("midrst_bg",     {20'd0, bg_rgb},    32'h004);
        check("midrst_border", {31'd0, border_en}, 32'd1);
        rst = 1'b0;
        step();
        expect_fb(3'd0, 12'h004, 1'b1);
        frame(3'b000);

        // hit in TITLE is dropped.
        for (int j = 0; j < 3; j++) begin
            expect_fb(3'd0, 12'h004, 1'b1);
            frame(3'b010);
        end

        // vblnk already high at reset release counts as a boundary.
        vga.vblnk = 1'b0;
        step();
        vga.vblnk = 1'b1;
        rst = 1'b1;
        repeat (2) step();
        expect_fb(3'd0, 12'h004, 1'b1);
        rst = 1'b0;
        step();
        check("rel_high_tick", {31'd0, frame_tick}, 32'd1);
        repeat (2) step();
        vga.vblnk = 1'b0;
        repeat (5) step();

        check("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
